// File: rtl/ps2_keycode_if.sv
// PS/2 pin pair and decoded key/error outputs for ps2_keycode.
// key_valid, parity_err and frame_err are one-cycle strobes with no backpressure (no ready).
interface ps2_keycode_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_valid;
  logic       parity_err;
  logic       frame_err;
  logic [1:0] dbg_state;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_valid, parity_err, frame_err, dbg_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_valid, parity_err, frame_err, dbg_state
  );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 set-2 receiver: sync + deglitch, 11-bit deframing, make/break/E0 decode to a held keycode.
// Optional macro PS2_ARROW_KEYS_EN maps E0-prefixed arrow keys onto the WASD keycodes.
module ps2_keycode #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic          Clk,
  input logic          Reset_n,
  ps2_keycode_if.slave bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FCW-1:0] filt_cnt;
  logic           clk_filt, clk_filt_d;
  logic           fall;

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [15:0] idle_cnt;
  logic        byte_rdy, perr_p, ferr_p;

  logic        brk, ext;
  logic        map_hit;
  logic [7:0]  map_val;
  logic [7:0]  keycode_q;
  logic        key_valid_q, parity_err_q, frame_err_q;

  // Lines idle high, so the synchronizers and the filtered clock reset to 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_s1     <= bus.ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= bus.ps2_data;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Frame FSM; the idle counter only runs mid-frame and restarts on every filtered edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      idle_cnt <= '0;
      byte_rdy <= 1'b0;
      perr_p   <= 1'b0;
      ferr_p   <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      perr_p   <= 1'b0;
      ferr_p   <= 1'b0;
      if (state != ST_IDLE && idle_cnt == 16'(TIMEOUT_CYCLES)) begin
        state    <= ST_IDLE;
        idle_cnt <= '0;
        ferr_p   <= 1'b1;
      end else if (fall) begin
        idle_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!dat_s2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_s2;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!dat_s2)                            ferr_p   <= 1'b1;
            else if ((^{shreg, par_bit}) == 1'b0)   perr_p   <= 1'b1;
            else                                    byte_rdy <= 1'b1;
          end
        endcase
      end else if (state != ST_IDLE) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    map_hit = 1'b0;
    map_val = 8'h00;
    if (!ext) begin
      case (shreg)
        8'h1C: begin map_hit = 1'b1; map_val = 8'h04; end
        8'h23: begin map_hit = 1'b1; map_val = 8'h07; end
        8'h1B: begin map_hit = 1'b1; map_val = 8'h16; end
        8'h1D: begin map_hit = 1'b1; map_val = 8'h1A; end
        8'h29: begin map_hit = 1'b1; map_val = 8'h2C; end
        8'h5A: begin map_hit = 1'b1; map_val = 8'h28; end
        default: ;
      endcase
    end
`ifdef PS2_ARROW_KEYS_EN
    else begin
      case (shreg)
        8'h75: begin map_hit = 1'b1; map_val = 8'h1A; end
        8'h6B: begin map_hit = 1'b1; map_val = 8'h04; end
        8'h72: begin map_hit = 1'b1; map_val = 8'h16; end
        8'h74: begin map_hit = 1'b1; map_val = 8'h07; end
        default: ;
      endcase
    end
`endif
  end

  // shreg stays stable here: the next DATA edge is at least a filter window after byte_rdy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      brk          <= 1'b0;
      ext          <= 1'b0;
      keycode_q    <= 8'h00;
      key_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      key_valid_q  <= 1'b0;
      parity_err_q <= perr_p;
      frame_err_q  <= ferr_p;
      if (perr_p || ferr_p) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_rdy) begin
        if (shreg == CODE_BRK) begin
          brk <= 1'b1;
        end else if (shreg == CODE_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (map_hit) begin
            if (!brk) begin
              if (map_val != keycode_q) begin
                keycode_q   <= map_val;
                key_valid_q <= 1'b1;
              end
            end else if (map_val == keycode_q) begin
              keycode_q   <= 8'h00;
              key_valid_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.keycode    = keycode_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_ps2_keycode.sv
// Self-checking bench for ps2_keycode: PS/2 frame driver, table-based key model, pulse scoreboard.
module tb_ps2_keycode;

  localparam int HALF = 20;

  logic clk;
  logic rst_n;
  int   cyc;

  ps2_keycode_if bus();

  ps2_keycode #(.FILTER_LEN(8), .TIMEOUT_CYCLES(50000)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int perr_seen = 0, ferr_seen = 0;
  int exp_perr  = 0, exp_ferr  = 0;
  int kv_cyc    = -1;
  int stop_cyc  = 0;

  // ---------------- reference model ----------------
  logic [7:0] base_map  [logic [7:0]];
  logic [7:0] arrow_map [logic [7:0]];
  logic [7:0] m_key;
  bit         m_brk, m_ext;

  task automatic model_reset();
    m_key = 8'h00;
    m_brk = 0;
    m_ext = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit         hit;
    logic [7:0] v;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      hit = 0;
      v   = 8'h00;
      if (!m_ext && base_map.exists(b)) begin hit = 1; v = base_map[b]; end
`ifdef PS2_ARROW_KEYS_EN
      if (m_ext && arrow_map.exists(b)) begin hit = 1; v = arrow_map[b]; end
`endif
      if (hit) begin
        if (!m_brk) begin
          if (v != m_key) begin m_key = v; exp_q.push_back(v); end
        end else if (v == m_key) begin
          m_key = 8'h00;
          exp_q.push_back(8'h00);
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.key_valid) begin
        kv_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL key_valid_unexpected keycode=%h expected no pulse", bus.keycode);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.keycode !== e) begin
            failures++;
            $display("FAIL key_valid_value keycode=%h expected=%h", bus.keycode, e);
          end
        end
      end
      if (bus.parity_err) perr_seen++;
      if (bus.frame_err)  ferr_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input bit last);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    logic [10:0] f;
    logic        p;
    p = par_ok ? ~(^b) : (^b);
    f = {stop_ok ? 1'b1 : 1'b0, p, b, 1'b0};
    if (!stop_ok)     begin exp_ferr++; m_brk = 0; m_ext = 0; end
    else if (!par_ok) begin exp_perr++; m_brk = 0; m_ext = 0; end
    else              model_byte(b);
    for (int i = 0; i < 11; i++) send_bit(f[i], i == 10);
    bus.ps2_data = 1'b1;
  endtask

  task automatic check_state(input string name);
    checks++;
    if (bus.keycode !== m_key) begin
      failures++;
      $display("FAIL %s keycode=%h expected=%h", name, bus.keycode, m_key);
    end
    checks++;
    if (perr_seen !== exp_perr || ferr_seen !== exp_ferr) begin
      failures++;
      $display("FAIL %s_errors perr=%0d ferr=%0d expected perr=%0d ferr=%0d",
               name, perr_seen, ferr_seen, exp_perr, exp_ferr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.keycode !== 8'h00 || bus.key_valid !== 1'b0 || bus.parity_err !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values keycode=%h kv=%b perr=%b ferr=%b st=%0d expected 00/0/0/0/0",
               bus.keycode, bus.key_valid, bus.parity_err, bus.frame_err, bus.dbg_state);
    end
  endtask

  task automatic test_make_break();
    kv_cyc = -1;
    send_frame(8'h1C, 1, 1);
    check_state("make_1c");
    checks++;
    if (kv_cyc - stop_cyc !== 12) begin
      failures++;
      $display("FAIL make_latency cycles=%0d expected=12", kv_cyc - stop_cyc);
    end
    send_frame(8'hF0, 1, 1);
    send_frame(8'h1C, 1, 1);
    check_state("break_1c");
    checks++;
    if (bus.keycode !== 8'h00) begin
      failures++;
      $display("FAIL break_1c_const keycode=%h expected=00", bus.keycode);
    end
  endtask

  task automatic test_overlap();
    send_frame(8'h1C, 1, 1);
    send_frame(8'h23, 1, 1);
    check_state("overlap_23");
    send_frame(8'hF0, 1, 1);
    send_frame(8'h1C, 1, 1);
    check_state("overlap_stale_break");
    send_frame(8'h23, 1, 1);
    check_state("overlap_typematic");
    send_frame(8'hF0, 1, 1);
    send_frame(8'h23, 1, 1);
    check_state("overlap_release");
  endtask

  task automatic test_parity();
    send_frame(8'h1D, 0, 1);
    check_state("parity_bad");
    send_frame(8'h1D, 1, 1);
    check_state("parity_recover");
    send_frame(8'hF0, 1, 1);
    send_frame(8'h1D, 0, 0);
    check_state("stop_and_parity_bad");
    send_frame(8'hF0, 1, 1);
    send_frame(8'h1D, 1, 1);
    check_state("parity_release");
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int          t0;
    f = {1'b1, ~(^8'h1B), 8'h1B, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(f[i], 0);
    bus.ps2_data = 1'b1;
    t0 = ferr_seen;
    repeat (49900) @(negedge clk);
    checks++;
    if (ferr_seen !== t0) begin
      failures++;
      $display("FAIL timeout_early ferr=%0d expected=%0d", ferr_seen, t0);
    end
    repeat (200) @(negedge clk);
    exp_ferr++;
    m_brk = 0;
    m_ext = 0;
    checks++;
    if (ferr_seen !== t0 + 1 || bus.dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL timeout_abort ferr=%0d st=%0d expected ferr=%0d st=0",
               ferr_seen, bus.dbg_state, t0 + 1);
    end
    send_frame(8'h1B, 1, 1);
    check_state("timeout_recover");
    send_frame(8'hF0, 1, 1);
    send_frame(8'h1B, 1, 1);
    check_state("timeout_release");
  endtask

  task automatic test_ext();
    logic [7:0] want;
`ifdef PS2_ARROW_KEYS_EN
    want = 8'h1A;
`else
    want = 8'h00;
`endif
    send_frame(8'hE0, 1, 1);
    send_frame(8'h75, 1, 1);
    check_state("ext_up");
    checks++;
    if (bus.keycode !== want) begin
      failures++;
      $display("FAIL ext_up_const keycode=%h expected=%h", bus.keycode, want);
    end
    send_frame(8'hE0, 1, 1);
    send_frame(8'hF0, 1, 1);
    send_frame(8'h75, 1, 1);
    check_state("ext_up_release");
    send_frame(8'hE0, 1, 1);
    send_frame(8'h1C, 1, 1);
    check_state("ext_1c_ignored");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h29, 1, 1);
    send_frame(8'h5A, 1, 1);
    send_frame(8'hF0, 1, 1);
    send_frame(8'h29, 1, 1);
    send_frame(8'hF0, 1, 1);
    send_frame(8'h5A, 1, 1);
    check_state("back_to_back");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_pending left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[14];
    logic [7:0] b;
    bit         p_ok, s_ok;
    pool = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h5A, 8'hF0, 8'hE0,
             8'h75, 8'h6B, 8'h72, 8'h74, 8'h12, 8'h44};
    for (int n = 0; n < 24; n++) begin
      b    = pool[$urandom_range(0, 13)];
      p_ok = ($urandom_range(0, 7) != 0);
      s_ok = ($urandom_range(0, 11) != 0);
      send_frame(b, p_ok, s_ok);
      check_state("random");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    f = {1'b1, ~(^8'h1C), 8'h1C, 1'b0};
    for (int i = 0; i < 6; i++) send_bit(f[i], 0);
    bus.ps2_data = f[6];
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (10) @(negedge clk);
    send_frame(8'h23, 1, 1);
    check_state("after_reset_23");
  endtask

  // ---------------- sequence ----------------
  initial begin
    base_map[8'h1C]  = 8'h04; base_map[8'h23]  = 8'h07; base_map[8'h1B] = 8'h16;
    base_map[8'h1D]  = 8'h1A; base_map[8'h29]  = 8'h2C; base_map[8'h5A] = 8'h28;
    arrow_map[8'h75] = 8'h1A; arrow_map[8'h6B] = 8'h04;
    arrow_map[8'h72] = 8'h16; arrow_map[8'h74] = 8'h07;
    model_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n        = 1'b0;
    repeat (5) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_make_break();
    test_overlap();
    test_parity();
    test_timeout();
    test_ext();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    repeat (40) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending left=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

PS/2 keyboard receiver and scan-code decoder that produces the 8-bit HID-style `keycode` consumed by the sprite movement logic. It samples the raw PS/2 clock and data lines, deframes 11-bit PS/2 frames, and tracks set-2 make, break (`F0`) and extended (`E0`) prefixes. It holds the most recently pressed mapped key on `keycode` until that key is released. It sits between the board PS/2 pins and the sprite/game logic, in the system clock domain.

## Interface
- `FILTER_LEN`, 8: number of consecutive equal samples before filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, 50000: `Clk` cycles without a filtered falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- `Clk` input, 1 bit: system clock, 50 MHz.
- `Reset_n` input, 1 bit: asynchronous reset, active-low.
- `ps2_clk` input, 1 bit: raw PS/2 clock, asynchronous to `Clk`.
- `ps2_data` input, 1 bit: raw PS/2 data, asynchronous to `Clk`.
- `keycode` output, 8 bits: currently held mapped key; `00` when no mapped key is held.
- `key_valid` output, 1 bit: one-cycle pulse whenever `keycode` changes value.
- `parity_err` output, 1 bit: one-cycle pulse when a frame fails the odd-parity check.
- `frame_err` output, 1 bit: one-cycle pulse on a bad stop bit or on timeout.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - `ps2_clk` is then deglitched: the filtered level changes only after `FILTER_LEN` consecutive identical synchronized samples.
  - A falling edge is detected on a filtered 1→0 transition.
- Frame FSM, advanced only on a filtered falling edge:
  - IDLE: data = 0 → DATA, bit count cleared. Data = 1 → stay in IDLE with no error.
  - DATA: shift in 8 bits LSB first → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: stop bit = 1 and odd parity over data+parity holds → deliver the byte, return to IDLE.
  - STOP, parity fails: `parity_err` pulses, byte dropped, return to IDLE.
  - STOP, stop bit = 0: `frame_err` pulses, byte dropped, return to IDLE. If parity also fails, only `frame_err` pulses.
- Timeout: in any state other than IDLE, the 16-bit idle counter reaching `TIMEOUT_CYCLES` aborts the frame.
  - FSM returns to IDLE; `frame_err` pulses; partial byte dropped.
  - The counter clears on every filtered falling edge.
- Decoder, acting on each delivered byte:
  - `F0` sets `brk`.
  - `E0` sets `ext`.
  - Any other byte is resolved using the current flags; both flags are then cleared.
- Any parity or frame error also clears `brk` and `ext`.
- Map, used when `ext` = 0:
  - `1C` → `04` (A)
  - `23` → `07` (D)
  - `1B` → `16` (S)
  - `1D` → `1A` (W)
  - `29` → `2C` (space)
  - `5A` → `28` (enter)
- Unmapped codes are ignored: no change to `keycode`, no `key_valid`.
- Make of a mapped key: `keycode` ← mapped value. `key_valid` pulses only if the value differs from the current one.
- Break of a mapped key:
  - If the mapped value equals `keycode`: `keycode` ← `00`, `key_valid` pulses.
  - Otherwise: no change.
- Typematic repeat of a held key produces no `key_valid`.

## Timing
- Reset values: `keycode` = `00`; `key_valid`, `parity_err`, `frame_err` = 0; FSM in IDLE; `brk` = `ext` = 0; idle counter = 0; filtered clock = 1.
- Reset asserted mid-frame discards all partial state immediately.
- Latency: `keycode`, `key_valid` and the error pulses update exactly 2 + `FILTER_LEN` + 2 `Clk` cycles after the raw `ps2_clk` falling edge of the stop bit. This is 12 cycles at the default.
- Timeout `frame_err` pulses in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Outputs are registered. No combinational path from the pins to the outputs.
- A new frame may start on the first filtered falling edge after the STOP edge; back-to-back frames lose no bytes.

## Configuration
- `PS2_ARROW_KEYS_EN` defined: when `ext` = 1, arrow keys are mapped and follow the same make/break rules as the base map.
  - `E0 75` → `1A`
  - `E0 6B` → `04`
  - `E0 72` → `16`
  - `E0 74` → `07`
- `PS2_ARROW_KEYS_EN` undefined: every byte resolved with `ext` = 1 is ignored. The `E0` prefix is still tracked and cleared normally, so an `E0 1C` sequence does not produce `04`.

## Test plan
- Frame `1C`, valid parity → `keycode` = `04`, one `key_valid` pulse 12 cycles after the stop edge. Then `F0 1C` → `keycode` = `00`, one pulse.
- Make `1C`, then make `23`, then `F0 1C` → `keycode` goes `04`, then `07`, and stays `07` with no third pulse. `F0 23` → `00`.
- Frame `1D` with even parity → `parity_err` pulses once; `keycode` unchanged; the next valid `1D` → `1A`.
- Drive start + 4 data bits, then hold `ps2_clk` high for 50000 cycles → `frame_err` pulses, FSM returns to IDLE, and the following valid `1B` frame → `16`.
- `E0 75`: with `PS2_ARROW_KEYS_EN` → `keycode` = `1A`; without it → `keycode` stays `00`, no pulse.
- `Reset_n` low during DATA bit 5 of a `1C` frame, then a full `23` frame → all outputs at reset values, then `keycode` = `07`, with no parity or frame error.
